iob_split_ot: RTL and testbench

//  Parametrised IOb-bus splitter: routes one master request stream to N_SLAVES peripheral slaves
//  by address field, tracking up to MAX_OT outstanding reads in a slave-index FIFO.

---
 rtl/iob_split_ot.sv | 149 ++++++++++++++
 tb/tb_iob_split_ot.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_split_ot.sv
// IOb splitter: one master to N_SLAVES slaves, with in-order read responses tracked by a slave-index FIFO.
// Optional decode-error handling is enabled by defining IOB_SPLIT_OT_DECERR_EN.
module iob_split_ot #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                N_SLAVES = 4,
    parameter int                P_SLAVES = ADDR_W - 2,
    parameter int                MAX_OT   = 4,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       cke_i,
    input  logic                       m_avalid_i,
    input  logic [ADDR_W-1:0]          m_addr_i,
    input  logic [DATA_W-1:0]          m_wdata_i,
    input  logic [DATA_W/8-1:0]        m_wstrb_i,
    output logic                       m_ready_o,
    output logic                       m_rvalid_o,
    output logic [DATA_W-1:0]          m_rdata_o,
    output logic [N_SLAVES-1:0]        s_avalid_o,
    output logic [ADDR_W-1:0]          s_addr_o,
    output logic [DATA_W-1:0]          s_wdata_o,
    output logic [DATA_W/8-1:0]        s_wstrb_o,
    input  logic [N_SLAVES-1:0]        s_ready_i,
    input  logic [N_SLAVES-1:0]        s_rvalid_i,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata_i,
    output logic [$clog2(MAX_OT):0]    ot_cnt_o,
    output logic                       err_o
);
    localparam int SEL_W = $clog2(N_SLAVES);
    localparam int PTR_W = $clog2(MAX_OT);
    localparam int CNT_W = PTR_W + 1;
`ifdef IOB_SPLIT_OT_DECERR_EN
    // One extra code point holds the decode-error token N_SLAVES.
    localparam int ENT_W = $clog2(N_SLAVES + 1);
`else
    localparam int ENT_W = SEL_W;
`endif

    logic [ENT_W-1:0] mem_q [MAX_OT];
    logic [ENT_W-1:0] mem_d [MAX_OT];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0]  sel_raw;
    logic [ENT_W-1:0]  sel_ent, tail_ent, head_ent;
    logic [PTR_W-1:0]  tail_ptr;
    logic              dec_err, is_read, empty, full, stall;
    logic              slv_ready, head_rvalid, head_err, accept, push, pop;
    logic [DATA_W-1:0] head_rdata;

    assign sel_raw = m_addr_i[P_SLAVES -: SEL_W];

    always_comb begin
        dec_err = 1'b0;
        sel_ent = ENT_W'(sel_raw);
        if (int'(sel_raw) >= N_SLAVES) begin
`ifdef IOB_SPLIT_OT_DECERR_EN
            dec_err = 1'b1;
            sel_ent = ENT_W'(N_SLAVES);
`else
            sel_ent = ENT_W'(N_SLAVES - 1);
`endif
        end
    end

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(MAX_OT));
    assign tail_ptr = wr_ptr_q - PTR_W'(1);
    assign tail_ent = mem_q[tail_ptr];
    assign head_ent = mem_q[rd_ptr_q];
    assign is_read  = (m_wstrb_i == '0);
    // Reads only follow reads to the same slave, so responses cannot reorder.
    assign stall    = is_read && (full || (!empty && (sel_ent != tail_ent)));

`ifdef IOB_SPLIT_OT_DECERR_EN
    assign head_err = (head_ent == ENT_W'(N_SLAVES));
`else
    assign head_err = 1'b0;
`endif

    always_comb begin
        slv_ready   = 1'b0;
        head_rvalid = 1'b0;
        head_rdata  = '0;
        s_avalid_o  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_ent == ENT_W'(k)) begin
                slv_ready     = s_ready_i[k];
                s_avalid_o[k] = m_avalid_i && !stall;
            end
            if (head_ent == ENT_W'(k)) begin
                head_rvalid = s_rvalid_i[k];
                head_rdata  = s_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign m_ready_o  = !stall && (dec_err || slv_ready);
    assign s_addr_o   = m_addr_i;
    assign s_wdata_o  = m_wdata_i;
    assign s_wstrb_o  = m_wstrb_i;
    assign m_rvalid_o = !empty && (head_err || head_rvalid);
    assign m_rdata_o  = empty ? '0 : (head_err ? ERR_DATA : head_rdata);
    assign ot_cnt_o   = cnt_q;
    assign err_o      = err_q;

    assign accept = m_avalid_i && m_ready_o;
    assign push   = cke_i && accept && is_read;
    assign pop    = cke_i && m_rvalid_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = cke_i ? (accept && dec_err) : err_q;
        if (push) begin
            mem_d[wr_ptr_q] = sel_ent;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < MAX_OT; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_iob_split_ot.sv
// Directed bench for iob_split_ot: a 4-slave instance for routing/ordering and a 3-slave
// instance for out-of-range select handling.
module tb_iob_split_ot;
    logic         clk = 1'b0;
    logic         rst, cke;
    logic         m_avalid;
    logic [31:0]  m_addr, m_wdata;
    logic [3:0]   m_wstrb;
    logic         m_ready, m_rvalid, err;
    logic [31:0]  m_rdata, s_addr, s_wdata;
    logic [3:0]   s_avalid, s_wstrb, s_ready, s_rvalid;
    logic [127:0] s_rdata;
    logic [2:0]   ot_cnt;

    logic         d3_avalid, d3_m_ready, d3_m_rvalid, d3_err;
    logic [31:0]  d3_addr, d3_m_rdata, d3_s_addr, d3_s_wdata;
    logic [2:0]   d3_s_avalid, d3_s_ready, d3_s_rvalid;
    logic [3:0]   d3_s_wstrb;
    logic [95:0]  d3_s_rdata;
    logic [2:0]   d3_ot_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    iob_split_ot u_dut (
        .clk_i(clk), .arst_i(rst), .cke_i(cke),
        .m_avalid_i(m_avalid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_ready_o(m_ready), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
        .s_ready_i(s_ready), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .ot_cnt_o(ot_cnt), .err_o(err)
    );

    iob_split_ot #(.N_SLAVES(3)) u_dut3 (
        .clk_i(clk), .arst_i(rst), .cke_i(cke),
        .m_avalid_i(d3_avalid), .m_addr_i(d3_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_ready_o(d3_m_ready), .m_rvalid_o(d3_m_rvalid), .m_rdata_o(d3_m_rdata),
        .s_avalid_o(d3_s_avalid), .s_addr_o(d3_s_addr), .s_wdata_o(d3_s_wdata), .s_wstrb_o(d3_s_wstrb),
        .s_ready_i(d3_s_ready), .s_rvalid_i(d3_s_rvalid), .s_rdata_i(d3_s_rdata),
        .ot_cnt_o(d3_ot_cnt), .err_o(d3_err)
    );

    function automatic logic [31:0] addr_of(input int sel);
        return 32'(sel) << 29;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_read(input int sel);
        m_avalid = 1'b1;
        m_addr   = addr_of(sel) | 32'h10;
        m_wstrb  = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cke = 1'b1;
        m_avalid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = 4'hF; s_rvalid = '0; s_rdata = '0;
        d3_avalid = 1'b0; d3_addr = '0; d3_s_ready = 3'b111; d3_s_rvalid = '0; d3_s_rdata = '0;
        #3;
        n_total++; if (ot_cnt !== 3'd0) $display("FAIL rst_cnt: got %0d exp 0", ot_cnt); else n_pass++;
        n_total++; if (m_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b exp 0", m_rvalid); else n_pass++;
        n_total++; if (m_rdata !== 32'h0) $display("FAIL rst_rdata: got %h exp 0", m_rdata); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b exp 0", err); else n_pass++;
        n_total++; if (s_avalid !== 4'b0) $display("FAIL rst_savalid: got %b exp 0", s_avalid); else n_pass++;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        m_avalid = 1'b1; m_addr = addr_of(1) | 32'h4; m_wdata = 32'h11; m_wstrb = 4'hF;
        #2;
        n_total++; if (s_avalid !== 4'b0010) $display("FAIL wr_savalid: got %b exp 0010", s_avalid); else n_pass++;
        n_total++; if (m_ready !== 1'b1) $display("FAIL wr_ready: got %b exp 1", m_ready); else n_pass++;
        n_total++; if (s_wdata !== 32'h11) $display("FAIL wr_wdata: got %h exp 11", s_wdata); else n_pass++;
        n_total++; if (s_addr !== 32'h2000_0004) $display("FAIL wr_addr: got %h exp 20000004", s_addr); else n_pass++;
        step();
        m_avalid = 1'b0;
        #2;
        n_total++; if (m_rvalid !== 1'b0) $display("FAIL wr_rvalid: got %b exp 0", m_rvalid); else n_pass++;
        n_total++; if (ot_cnt !== 3'd0) $display("FAIL wr_cnt: got %0d exp 0", ot_cnt); else n_pass++;
        step();
    endtask

    task automatic test_max_ot();
        for (int i = 0; i < 4; i++) begin
            drive_read(2);
            step();
        end
        #2;
        n_total++; if (ot_cnt !== 3'd4) $display("FAIL ot_full_cnt: got %0d exp 4", ot_cnt); else n_pass++;
        n_total++; if (m_ready !== 1'b0) $display("FAIL ot_full_ready: got %b exp 0", m_ready); else n_pass++;
        n_total++; if (s_avalid !== 4'b0) $display("FAIL ot_full_savalid: got %b exp 0", s_avalid); else n_pass++;
        s_rvalid = 4'b0100; s_rdata[2*32 +: 32] = 32'hA0;
        #1;
        n_total++; if (m_rvalid !== 1'b1) $display("FAIL ot_rv0: got %b exp 1", m_rvalid); else n_pass++;
        n_total++; if (m_rdata !== 32'hA0) $display("FAIL ot_rd0: got %h exp a0", m_rdata); else n_pass++;
        n_total++; if (m_ready !== 1'b0) $display("FAIL ot_nobypass: got %b exp 0", m_ready); else n_pass++;
        step();
        s_rdata[2*32 +: 32] = 32'hA1;
        #2;
        n_total++; if (m_ready !== 1'b1) $display("FAIL ot_ready_after_pop: got %b exp 1", m_ready); else n_pass++;
        n_total++; if (m_rdata !== 32'hA1) $display("FAIL ot_rd1: got %h exp a1", m_rdata); else n_pass++;
        n_total++; if (ot_cnt !== 3'd3) $display("FAIL ot_cnt3: got %0d exp 3", ot_cnt); else n_pass++;
        step();
        m_avalid = 1'b0;
        for (int j = 2; j <= 4; j++) begin
            s_rdata[2*32 +: 32] = 32'hA0 + 32'(j);
            #2;
            n_total++; if (m_rdata !== 32'hA0 + 32'(j)) $display("FAIL ot_rd%0d: got %h exp %h", j, m_rdata, 32'hA0 + 32'(j)); else n_pass++;
            n_total++; if (ot_cnt !== 3'(5 - j)) $display("FAIL ot_cnt_j%0d: got %0d exp %0d", j, ot_cnt, 5 - j); else n_pass++;
            step();
        end
        s_rvalid = '0;
        #2;
        n_total++; if (ot_cnt !== 3'd0) $display("FAIL ot_drained: got %0d exp 0", ot_cnt); else n_pass++;
        n_total++; if (m_rvalid !== 1'b0) $display("FAIL ot_rv_empty: got %b exp 0", m_rvalid); else n_pass++;
        step();
    endtask

    task automatic test_cross_slave();
        drive_read(0);
        step();
        drive_read(3);
        #2;
        n_total++; if (m_ready !== 1'b0) $display("FAIL xs_ready: got %b exp 0", m_ready); else n_pass++;
        n_total++; if (s_avalid !== 4'b0) $display("FAIL xs_savalid: got %b exp 0", s_avalid); else n_pass++;
        step();
        n_total++; if (ot_cnt !== 3'd1) $display("FAIL xs_cnt: got %0d exp 1", ot_cnt); else n_pass++;
        s_rvalid = 4'b0001; s_rdata[0 +: 32] = 32'h77;
        #2;
        n_total++; if (m_rdata !== 32'h77) $display("FAIL xs_rd0: got %h exp 77", m_rdata); else n_pass++;
        n_total++; if (m_ready !== 1'b0) $display("FAIL xs_ready_pop: got %b exp 0", m_ready); else n_pass++;
        step();
        s_rvalid = '0;
        #2;
        n_total++; if (s_avalid !== 4'b1000) $display("FAIL xs_savalid3: got %b exp 1000", s_avalid); else n_pass++;
        n_total++; if (m_ready !== 1'b1) $display("FAIL xs_ready3: got %b exp 1", m_ready); else n_pass++;
        step();
        m_avalid = 1'b0;
        s_rvalid = 4'b1000; s_rdata[3*32 +: 32] = 32'h33;
        #2;
        n_total++; if (m_rdata !== 32'h33) $display("FAIL xs_rd3: got %h exp 33", m_rdata); else n_pass++;
        step();
        s_rvalid = '0;
        n_total++; if (ot_cnt !== 3'd0) $display("FAIL xs_drained: got %0d exp 0", ot_cnt); else n_pass++;
    endtask

    task automatic test_spurious();
        drive_read(0);
        step();
        m_avalid = 1'b0;
        s_rvalid = 4'b0010; s_rdata[1*32 +: 32] = 32'hBAD;
        #2;
        n_total++; if (m_rvalid !== 1'b0) $display("FAIL sp_rvalid: got %b exp 0", m_rvalid); else n_pass++;
        step();
        n_total++; if (ot_cnt !== 3'd1) $display("FAIL sp_cnt: got %0d exp 1", ot_cnt); else n_pass++;
        s_rvalid = 4'b0001; s_rdata[0 +: 32] = 32'h55;
        #2;
        n_total++; if (m_rvalid !== 1'b1) $display("FAIL sp_rv_head: got %b exp 1", m_rvalid); else n_pass++;
        n_total++; if (m_rdata !== 32'h55) $display("FAIL sp_rd_head: got %h exp 55", m_rdata); else n_pass++;
        step();
        s_rvalid = '0;
        n_total++; if (ot_cnt !== 3'd0) $display("FAIL sp_drained: got %0d exp 0", ot_cnt); else n_pass++;
    endtask

    task automatic test_cke();
        cke = 1'b0;
        drive_read(1);
        #2;
        n_total++; if (m_ready !== 1'b1) $display("FAIL cke_ready: got %b exp 1", m_ready); else n_pass++;
        step();
        m_avalid = 1'b0;
        n_total++; if (ot_cnt !== 3'd0) $display("FAIL cke_frozen: got %0d exp 0", ot_cnt); else n_pass++;
        cke = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        drive_read(2);
        step();
        step();
        m_avalid = 1'b0;
        n_total++; if (ot_cnt !== 3'd2) $display("FAIL mr_cnt2: got %0d exp 2", ot_cnt); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (ot_cnt !== 3'd0) $display("FAIL mr_cnt0: got %0d exp 0", ot_cnt); else n_pass++;
        n_total++; if (m_rvalid !== 1'b0) $display("FAIL mr_rvalid: got %b exp 0", m_rvalid); else n_pass++;
        #2;
        rst = 1'b0;
        s_rvalid = 4'b0100; s_rdata[2*32 +: 32] = 32'h99;
        #1;
        n_total++; if (m_rvalid !== 1'b0) $display("FAIL mr_late_rv: got %b exp 0", m_rvalid); else n_pass++;
        n_total++; if (m_rdata !== 32'h0) $display("FAIL mr_late_rd: got %h exp 0", m_rdata); else n_pass++;
        step();
        s_rvalid = '0;
        n_total++; if (ot_cnt !== 3'd0) $display("FAIL mr_cnt_after: got %0d exp 0", ot_cnt); else n_pass++;
    endtask

    task automatic test_decode();
        d3_avalid = 1'b1; d3_addr = addr_of(3); m_wstrb = 4'h0;
        #2;
        n_total++; if (d3_m_ready !== 1'b1) $display("FAIL dec_ready: got %b exp 1", d3_m_ready); else n_pass++;
`ifdef IOB_SPLIT_OT_DECERR_EN
        n_total++; if (d3_s_avalid !== 3'b000) $display("FAIL dec_savalid: got %b exp 000", d3_s_avalid); else n_pass++;
        step();
        d3_avalid = 1'b0;
        n_total++; if (d3_err !== 1'b1) $display("FAIL dec_err: got %b exp 1", d3_err); else n_pass++;
        n_total++; if (d3_m_rvalid !== 1'b1) $display("FAIL dec_rvalid: got %b exp 1", d3_m_rvalid); else n_pass++;
        n_total++; if (d3_m_rdata !== 32'hDEADBEEF) $display("FAIL dec_rdata: got %h exp deadbeef", d3_m_rdata); else n_pass++;
        step();
        n_total++; if (d3_err !== 1'b0) $display("FAIL dec_err_pulse: got %b exp 0", d3_err); else n_pass++;
        n_total++; if (d3_ot_cnt !== 3'd0) $display("FAIL dec_cnt: got %0d exp 0", d3_ot_cnt); else n_pass++;
`else
        n_total++; if (d3_s_avalid !== 3'b100) $display("FAIL dec_route: got %b exp 100", d3_s_avalid); else n_pass++;
        step();
        d3_avalid = 1'b0;
        n_total++; if (d3_err !== 1'b0) $display("FAIL dec_err: got %b exp 0", d3_err); else n_pass++;
        d3_s_rvalid = 3'b100; d3_s_rdata[2*32 +: 32] = 32'h22;
        #2;
        n_total++; if (d3_m_rvalid !== 1'b1) $display("FAIL dec_rvalid: got %b exp 1", d3_m_rvalid); else n_pass++;
        n_total++; if (d3_m_rdata !== 32'h22) $display("FAIL dec_rdata: got %h exp 22", d3_m_rdata); else n_pass++;
        step();
        d3_s_rvalid = '0;
        n_total++; if (d3_ot_cnt !== 3'd0) $display("FAIL dec_cnt: got %0d exp 0", d3_ot_cnt); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_max_ot();
        test_cross_slave();
        test_spurious();
        test_cke();
        test_reset_mid();
        test_decode();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running exp finished");
        $fatal(1, "bench timeout");
    end
endmodule
